cw_output: RTL

CW_OUTPUT -- requirements
Module: cw_output

---
 rtl/cw_output_pkg.sv | 25 ++
 rtl/cw_output_vc.sv | 71 +++++++
 rtl/cw_output.sv | 86 ++++++++
 3 files changed

// File: rtl/cw_output_pkg.sv
// Shared router constants and encodings for the cw output port.
package cw_output_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned HOP_MSB    = 55;
  localparam int unsigned HOP_LSB    = 48;

  // Phase carried on the polarity input
  typedef enum logic {
    PHASE_EVEN = 1'b0,
    PHASE_ODD  = 1'b1
  } phase_e;

  typedef enum logic {
    VC_EMPTY = 1'b0,
    VC_FULL  = 1'b1
  } vc_state_e;

  // Which source wins when both cw and pe request the same VC
  typedef enum logic {
    PRIO_CW = 1'b0,
    PRIO_PE = 1'b1
  } rr_prio_e;

endpackage

// File: rtl/cw_output_vc.sv
// One virtual channel: single-entry buffer, full flag and cw/pe round-robin arbiter.
module cw_output_vc #(
  parameter int unsigned DATA_WIDTH = cw_output_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cw,
  input  logic                  req_pe,
  input  logic [DATA_WIDTH-1:0] data_cw,
  input  logic [DATA_WIDTH-1:0] data_pe,
  input  logic                  drain,
  output logic                  grant_cw_c,
  output logic                  grant_pe_c,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] data
);
  import cw_output_pkg::*;

  vc_state_e             state_q, state_d;
  rr_prio_e              prio_q, prio_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VC_EMPTY;
      prio_q  <= PRIO_CW;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
    end
  end

  // Grants only from an empty buffer, so a fill can never land on a drain
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    data_d     = data_q;
    grant_cw_c = 1'b0;
    grant_pe_c = 1'b0;
    case (state_q)
      VC_EMPTY: begin
        if (!rst) begin
          if (req_cw && (!req_pe || prio_q == PRIO_CW)) begin
            grant_cw_c = 1'b1;
            data_d     = data_cw;
            prio_d     = PRIO_PE;
            state_d    = VC_FULL;
          end else if (req_pe) begin
            grant_pe_c = 1'b1;
            data_d     = data_pe;
            prio_d     = PRIO_CW;
            state_d    = VC_FULL;
          end
        end
      end
      VC_FULL: begin
        if (drain) begin
          state_d = VC_EMPTY;
          data_d  = '0;
        end
      end
      default: state_d = VC_EMPTY;
    endcase
  end

  assign full = (state_q == VC_FULL);
  assign data = data_q;

endmodule

// File: rtl/cw_output.sv
// CW output port: two VC buffers, polarity-selected transmit with hop-count decrement.
module cw_output #(
  parameter int unsigned DATA_WIDTH = cw_output_pkg::DATA_WIDTH,
  parameter int unsigned HOP_MSB    = cw_output_pkg::HOP_MSB,
  parameter int unsigned HOP_LSB    = cw_output_pkg::HOP_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_cw_even,
  input  logic                  request_cw_odd,
  input  logic                  request_pe_even,
  input  logic                  request_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_in_cw_even,
  input  logic [DATA_WIDTH-1:0] data_in_cw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_pe_even,
  input  logic [DATA_WIDTH-1:0] data_in_pe_odd,
  output logic                  grant_cw_even,
  output logic                  grant_cw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  input  logic                  cwro,
  output logic                  cwso,
  output logic [DATA_WIDTH-1:0] cwdo
);
  import cw_output_pkg::*;

  localparam int unsigned HOP_W = HOP_MSB - HOP_LSB + 1;

  logic                  even_full, odd_full;
  logic [DATA_WIDTH-1:0] even_data, odd_data;
  logic                  sel_odd_c, sel_full_c, tx_c;
  logic                  drain_even_c, drain_odd_c;
  logic [DATA_WIDTH-1:0] sel_data_c, tx_data_c;

  cw_output_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_even (
    .clk        (clk),
    .rst        (rst),
    .req_cw     (request_cw_even),
    .req_pe     (request_pe_even),
    .data_cw    (data_in_cw_even),
    .data_pe    (data_in_pe_even),
    .drain      (drain_even_c),
    .grant_cw_c (grant_cw_even),
    .grant_pe_c (grant_pe_even),
    .full       (even_full),
    .data       (even_data)
  );

  cw_output_vc #(.DATA_WIDTH(DATA_WIDTH)) u_vc_odd (
    .clk        (clk),
    .rst        (rst),
    .req_cw     (request_cw_odd),
    .req_pe     (request_pe_odd),
    .data_cw    (data_in_cw_odd),
    .data_pe    (data_in_pe_odd),
    .drain      (drain_odd_c),
    .grant_cw_c (grant_cw_odd),
    .grant_pe_c (grant_pe_odd),
    .full       (odd_full),
    .data       (odd_data)
  );

  // Only the phase-selected VC may drain; a zero hop count wraps rather than blocks
  always_comb begin
    sel_odd_c    = (phase_e'(polarity) == PHASE_ODD);
    sel_full_c   = sel_odd_c ? odd_full : even_full;
    sel_data_c   = sel_odd_c ? odd_data : even_data;
    tx_c         = sel_full_c && cwro;
    drain_even_c = tx_c && !sel_odd_c;
    drain_odd_c  = tx_c && sel_odd_c;
    tx_data_c    = sel_data_c;
    tx_data_c[HOP_MSB:HOP_LSB] = sel_data_c[HOP_MSB:HOP_LSB] - HOP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cwso <= 1'b0;
      cwdo <= '0;
    end else begin
      cwso <= tx_c;
      if (tx_c) cwdo <= tx_data_c;
    end
  end

endmodule
